// File: rtl/blackjack_dealer.sv
// Blackjack table controller: deals cards from an external source, tracks both hands,
// serves the player decision interface and draws the dealer hand until it reaches 17.
module blackjack_dealer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit,
  input  logic       hold,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card,
  output logic [4:0] p_high,
  output logic [4:0] p_low,
  output logic [4:0] d_high,
  output logic       player_turn,
  output logic       done,
  output logic [1:0] result
);

  typedef enum logic [3:0] {
    StIdle, StDealP1, StDealD1, StDealP2, StDealD2, StPlayer,
    StPDraw, StDealer, StDDraw, StResolve, StDone
  } state_e;

  localparam logic [1:0] ResNone = 2'b00;
  localparam logic [1:0] ResWin  = 2'b01;
  localparam logic [1:0] ResLose = 2'b10;
  localparam logic [1:0] ResPush = 2'b11;

  state_e     state_q, state_d;
  logic [4:0] p_low_q, p_low_d, d_low_q, d_low_d;
  logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [3:0] d_up_q, d_up_d;
  logic [1:0] result_q, result_d;

  logic       card_ok, accept, is_ace, p_take, d_take, show_full;
  logic [3:0] card_val;
  logic [4:0] d_high_full, p_eff, d_eff;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [3:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {2'b00, b};
    return (s > 6'd31) ? 5'd31 : s[4:0];
  endfunction

  function automatic logic [4:0] high_of(input logic [4:0] low, input logic ace);
    return ace ? sat_add(low, 4'd10) : low;
  endfunction

  function automatic logic [4:0] eff_of(input logic [4:0] high, input logic [4:0] low);
    return (high <= 5'd21) ? high : low;
  endfunction

  assign card_ok     = card_valid && (card != 4'd0) && (card <= 4'd13);
  assign is_ace      = (card == 4'd1);
  assign card_val    = (card > 4'd10) ? 4'd10 : card;
  assign accept      = card_req && card_ok;
  assign p_high      = high_of(p_low_q, p_ace_q);
  assign p_low       = p_low_q;
  assign d_high_full = high_of(d_low_q, d_ace_q);
  assign p_eff       = eff_of(p_high, p_low_q);
  assign d_eff       = eff_of(d_high_full, d_low_q);
  assign result      = result_q;

  always_comb begin
    card_req    = 1'b0;
    player_turn = 1'b0;
    done        = 1'b0;
    show_full   = 1'b0;
    case (state_q)
      StDealP1, StDealD1, StDealP2, StDealD2, StPDraw: card_req = 1'b1;
      StDDraw: begin
        card_req  = 1'b1;
        show_full = 1'b1;
      end
      StPlayer:           player_turn = 1'b1;
      StDealer, StResolve: show_full  = 1'b1;
      StDone: begin
        done      = 1'b1;
        show_full = 1'b1;
      end
      default: ;
    endcase
    // Until the player stands only the upcard is exposed.
    d_high = show_full ? d_high_full : {1'b0, d_up_q};
  end

  always_comb begin
    state_d  = state_q;
    p_low_d  = p_low_q;
    p_ace_d  = p_ace_q;
    d_low_d  = d_low_q;
    d_ace_d  = d_ace_q;
    d_up_d   = d_up_q;
    result_d = result_q;
    p_take   = 1'b0;
    d_take   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StDealP1;
          p_low_d  = '0;
          p_ace_d  = 1'b0;
          d_low_d  = '0;
          d_ace_d  = 1'b0;
          d_up_d   = '0;
          result_d = ResNone;
        end
      end
      StDealP1: if (accept) begin
        p_take  = 1'b1;
        state_d = StDealD1;
      end
      StDealD1: if (accept) begin
        d_take  = 1'b1;
        d_up_d  = is_ace ? 4'd11 : card_val;
        state_d = StDealP2;
      end
      StDealP2: if (accept) begin
        p_take  = 1'b1;
        state_d = StDealD2;
      end
      StDealD2: if (accept) begin
        d_take  = 1'b1;
        state_d = StPlayer;
      end
      StPlayer: begin
        if (p_low_q > 5'd21)  state_d = StResolve;
        else if (hold)        state_d = StDealer;
        else if (hit)         state_d = StPDraw;
      end
      StPDraw: if (accept) begin
        p_take  = 1'b1;
        state_d = StPlayer;
      end
      StDealer: state_d = (d_eff >= 5'd17) ? StResolve : StDDraw;
      StDDraw: if (accept) begin
        d_take  = 1'b1;
        state_d = StDealer;
      end
      StResolve: begin
        if (p_low_q > 5'd21)   result_d = ResLose;
        else if (d_eff > 5'd21) result_d = ResWin;
        else if (p_eff > d_eff) result_d = ResWin;
        else if (p_eff == d_eff) result_d = ResPush;
        else                    result_d = ResLose;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
    if (p_take) begin
      p_low_d = sat_add(p_low_q, card_val);
      p_ace_d = p_ace_q | is_ace;
    end
    if (d_take) begin
      d_low_d = sat_add(d_low_q, card_val);
      d_ace_d = d_ace_q | is_ace;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      p_low_q  <= '0;
      p_ace_q  <= 1'b0;
      d_low_q  <= '0;
      d_ace_q  <= 1'b0;
      d_up_q   <= '0;
      result_q <= ResNone;
    end else begin
      state_q  <= state_d;
      p_low_q  <= p_low_d;
      p_ace_q  <= p_ace_d;
      d_low_q  <= d_low_d;
      d_ace_q  <= d_ace_d;
      d_up_q   <= d_up_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_blackjack_dealer.sv
// Randomized bench for blackjack_dealer: scripted and random rounds are scored against a
// hand model built from running card sums and ace flags.
module tb_blackjack_dealer;

  logic       clk = 1'b0;
  logic       rst_n, start, hit, hold, card_valid;
  logic [3:0] card;
  logic       card_req, player_turn, done;
  logic [4:0] p_high, p_low, d_high;
  logic [1:0] result;

  blackjack_dealer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .hit         (hit),
    .hold        (hold),
    .card_req    (card_req),
    .card_valid  (card_valid),
    .card        (card),
    .p_high      (p_high),
    .p_low       (p_low),
    .d_high      (d_high),
    .player_turn (player_turn),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Hand model: unsaturated sums plus ace flags.
  int p_sum, d_sum, d_up;
  bit p_ace, d_ace;
  int sc_cards[$];
  int sc_acts[$];   // 0 hold, 1 hit, 2 hit+hold, 3 idle with stray card

  function automatic int card_value(input int r);
    return (r > 10) ? 10 : r;
  endfunction

  function automatic int tot_low(input int s);
    return (s > 31) ? 31 : s;
  endfunction

  function automatic int tot_high(input int s, input bit ace);
    return tot_low(s + (ace ? 10 : 0));
  endfunction

  function automatic int eff(input int s, input bit ace);
    return (tot_high(s, ace) <= 21) ? tot_high(s, ace) : tot_low(s);
  endfunction

  function automatic int exp_result();
    if (tot_low(p_sum) > 21) return 2;
    if (eff(d_sum, d_ace) > 21) return 1;
    if (eff(p_sum, p_ace) > eff(d_sum, d_ace)) return 1;
    if (eff(p_sum, p_ace) == eff(d_sum, d_ace)) return 3;
    return 2;
  endfunction

  function automatic int next_card();
    if (sc_cards.size() > 0) return sc_cards.pop_front();
    return $urandom_range(1, 13);
  endfunction

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !card_req; i++) @(negedge clk);
    check(tag, int'(card_req), 1);
  endtask

  task automatic give_card(input int rank, input bit to_player);
    int bad;
    wait_req("card_req wait");
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      check("req held idle", int'(card_req), 1);
    end
    if ($urandom_range(0, 3) == 0) begin
      bad = $urandom_range(0, 2);
      card_valid = 1'b1;
      card = (bad == 0) ? 4'd0 : ((bad == 1) ? 4'd14 : 4'd15);
      @(negedge clk);
      check("bad card req held", int'(card_req), 1);
      check("bad card p_low", int'(p_low), tot_low(p_sum));
    end
    card_valid = 1'b1;
    card = 4'(rank);
    @(negedge clk);
    card_valid = 1'b0;
    card = 4'd0;
    if (to_player) begin
      p_sum += card_value(rank);
      p_ace |= (rank == 1);
    end else begin
      d_sum += card_value(rank);
      d_ace |= (rank == 1);
    end
  endtask

  task automatic start_round();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    p_sum = 0; d_sum = 0; p_ace = 0; d_ace = 0; d_up = 0;
    check("start card_req", int'(card_req), 1);
    check("start p_low", int'(p_low), 0);
    check("start p_high", int'(p_high), 0);
    check("start d_high", int'(d_high), 0);
    check("start result", int'(result), 0);
    check("start done", int'(done), 0);
  endtask

  task automatic play_round(input bit rst_in_ddraw);
    int r, act, req_seen, lat;
    bit stood;
    start_round();
    for (int k = 0; k < 4; k++) begin
      r = next_card();
      give_card(r, (k % 2) == 0);
      if (k == 1) d_up = (r == 1) ? 11 : card_value(r);
    end
    check("deal player_turn", int'(player_turn), 1);
    check("deal p_high", int'(p_high), tot_high(p_sum, p_ace));
    check("deal p_low", int'(p_low), tot_low(p_sum));
    check("deal upcard", int'(d_high), d_up);
    stood = 0;
    for (int it = 0; it < 40 && !stood && tot_low(p_sum) <= 21; it++) begin
      if (sc_acts.size() > 0) act = sc_acts.pop_front();
      else begin
        r = $urandom_range(0, 9);
        act = (r < 2) ? 3 : (r < 5) ? 1 : (r == 5) ? 2 : 0;
      end
      if (act == 3) begin
        card_valid = 1'b1;
        card = 4'($urandom_range(1, 13));
        @(negedge clk);
        card_valid = 1'b0;
        check("stray card turn", int'(player_turn), 1);
        check("stray card p_low", int'(p_low), tot_low(p_sum));
        check("stray card p_high", int'(p_high), tot_high(p_sum, p_ace));
      end else if (act == 1) begin
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        check("hit draw req", int'(card_req), 1);
        give_card(next_card(), 1);
        check("hit player_turn", int'(player_turn), 1);
        check("hit p_high", int'(p_high), tot_high(p_sum, p_ace));
        check("hit p_low", int'(p_low), tot_low(p_sum));
        check("hit upcard", int'(d_high), d_up);
      end else begin
        hold = 1'b1;
        hit = (act == 2);
        @(negedge clk);
        hold = 1'b0;
        hit = 1'b0;
        check("hold leaves player", int'(player_turn), 0);
        check("hold no draw", int'(card_req), 0);
        check("hold d_high full", int'(d_high), tot_high(d_sum, d_ace));
        stood = 1;
      end
    end
    if (stood) begin
      for (int it = 0; it < 20 && eff(d_sum, d_ace) < 17; it++) begin
        if (rst_in_ddraw) begin
          wait_req("d_draw req");
          rst_n = 1'b0;
          card_valid = 1'b1;
          card = 4'd5;
          #1;
          check("rst card_req", int'(card_req), 0);
          check("rst p_low", int'(p_low), 0);
          check("rst p_high", int'(p_high), 0);
          check("rst d_high", int'(d_high), 0);
          check("rst done", int'(done), 0);
          check("rst result", int'(result), 0);
          check("rst player_turn", int'(player_turn), 0);
          @(negedge clk);
          check("rst card ignored", int'(p_low) + int'(d_high), 0);
          rst_n = 1'b1;
          card_valid = 1'b0;
          card = 4'd0;
          @(negedge clk);
          check("post rst idle req", int'(card_req), 0);
          check("post rst done", int'(done), 0);
          return;
        end
        give_card(next_card(), 0);
        check("dealer d_high", int'(d_high), tot_high(d_sum, d_ace));
      end
    end
    req_seen = 0;
    lat = 0;
    while (lat < 10 && !done) begin
      if (card_req) req_seen++;
      @(negedge clk);
      lat++;
    end
    check("done reached", int'(done), 1);
    check("resolve latency", lat, 2);
    check("no extra card_req", req_seen, 0);
    check("result", int'(result), exp_result());
    check("done p_high", int'(p_high), tot_high(p_sum, p_ace));
    check("done p_low", int'(p_low), tot_low(p_sum));
    check("done d_high", int'(d_high), tot_high(d_sum, d_ace));
    check("done player_turn", int'(player_turn), 0);
    check("done card_req", int'(card_req), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; hold = 1'b0;
    card_valid = 1'b0; card = 4'd0;
    @(negedge clk);
    @(negedge clk);
    check("reset card_req", int'(card_req), 0);
    check("reset totals", int'(p_high) + int'(p_low) + int'(d_high), 0);
    check("reset result", int'(result), 0);
    check("reset done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    sc_cards = '{10, 6, 2, 10, 5};    sc_acts = '{0};    play_round(0);
    sc_cards = '{1, 9, 6, 7, 10, 2};  sc_acts = '{1, 0}; play_round(0);
    sc_cards = '{10, 5, 6, 5, 13};    sc_acts = '{1};    play_round(0);
    sc_cards = '{10, 1, 8, 6};        sc_acts = '{0};    play_round(0);
    sc_cards = '{10, 2, 9, 3};        sc_acts = '{2};    play_round(1);
    sc_cards = '{9, 10, 9, 10};       sc_acts = '{2};    play_round(0);

    for (int n = 0; n < 60; n++) play_round(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
